// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Processor memory port with RAM, I/O window, bulk-load and clear.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int                ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] IO_BASE = 12'hFF0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic              m_rw,
    input  logic [15:0]       m_data,
    output logic [15:0]       m_q,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [15:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              clr_start,
    output logic              busy,
    output logic [ADDR_W:0]   ld_count
);

    localparam int                c_DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_IO_SPAN  = ADDR_W'(16);
    localparam logic [ADDR_W-1:0] c_PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_LOAD  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [15:0]       r_mem [c_DEPTH];
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_ld_count;
    logic [15:0]       r_led;
    logic [15:0]       r_q;
    logic [15:0]       r_cyc;
    logic [15:0]       r_sw_meta;
    logic [15:0]       r_sw_sync;

    logic [ADDR_W-1:0] w_m_off;
    logic [ADDR_W-1:0] w_ptr_off;
    logic              w_m_io;
    logic              w_ptr_io;
    logic [15:0]       w_io_rd;
    logic [15:0]       w_rd_data;
    logic              w_busy;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [15:0]       w_ram_wdata;
    logic              w_led_we;
    logic              w_ld_accept;

    // Window membership by offset so an unaligned IO_BASE still works.
    assign w_m_off   = m_addr - IO_BASE;
    assign w_ptr_off = r_ptr - IO_BASE;
    assign w_m_io    = (w_m_off < c_IO_SPAN);
    assign w_ptr_io  = (w_ptr_off < c_IO_SPAN);

    assign w_busy    = (r_state != S_RUN);
    assign busy      = w_busy;
    assign ld_ready  = (r_state == S_LOAD);
    assign ld_count  = r_ld_count;
    assign led_out   = r_led;
    assign m_q       = r_q;

    always_comb begin
        w_io_rd = 16'h0000;
        case (w_m_off[3:0])
            4'd0:    w_io_rd = r_sw_sync;
            4'd1:    w_io_rd = r_led;
            4'd2:    w_io_rd = r_cyc;
            4'd3:    w_io_rd = {15'b0, w_busy};
            default: w_io_rd = 16'h0000;
        endcase
    end

    assign w_rd_data = w_m_io ? w_io_rd : r_mem[m_addr];

    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_addr  = m_addr;
        w_ram_wdata = m_data;
        w_led_we    = 1'b0;
        w_ld_accept = 1'b0;
        case (r_state)
            S_RUN: begin
                if (clr_start) begin
                    w_state_nxt = S_CLEAR;
                end else if (ld_start) begin
                    w_state_nxt = S_LOAD;
                end
                if (m_rw && !w_m_io) begin
                    w_ram_we = 1'b1;
                end
                if (m_rw && w_m_io && (w_m_off[3:0] == 4'd1)) begin
                    w_led_we = 1'b1;
                end
            end
            S_LOAD: begin
                w_ram_addr  = r_ptr;
                w_ram_wdata = ld_data;
                if (ld_valid) begin
                    w_ld_accept = 1'b1;
                    w_ram_we    = !w_ptr_io;
                    if (ld_last) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_CLEAR: begin
                w_ram_addr  = r_ptr;
                w_ram_wdata = 16'h0000;
                w_ram_we    = !w_ptr_io;
                if (r_ptr == c_ADDR_MAX) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_ld_count <= '0;
            r_led      <= 16'h0000;
            r_q        <= 16'h0000;
            r_cyc      <= 16'h0000;
            r_sw_meta  <= 16'h0000;
            r_sw_sync  <= 16'h0000;
        end else begin
            r_cyc     <= r_cyc + 16'd1;
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
            r_q       <= w_busy ? 16'h0000 : w_rd_data;
            if (w_led_we) begin
                r_led <= m_data;
            end
            case (r_state)
                S_RUN: begin
                    if (clr_start) begin
                        r_ptr <= '0;
                    end else if (ld_start) begin
                        r_ptr      <= ld_base;
                        r_ld_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_ld_accept) begin
                        r_ptr      <= r_ptr + c_PTR_ONE;
                        r_ld_count <= r_ld_count + c_CNT_ONE;
                    end
                end
                S_CLEAR: r_ptr <= r_ptr + c_PTR_ONE;
                default: ;
            endcase
        end
    end

    // RAM contents survive reset; writes are held off while reset is asserted.
    always_ff @(posedge clock) begin
        if (w_ram_we && !reset) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder (vectors, sequences, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] m_addr;
    logic        m_rw;
    logic [15:0] m_data;
    logic [15:0] m_q;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        ld_start;
    logic [11:0] ld_base;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        clr_start;
    logic        busy;
    logic [12:0] ld_count;

    mem_responder #(.ADDR_W(12), .IO_BASE(12'hFF0)) dut (
        .clock(clock), .reset(reset),
        .m_addr(m_addr), .m_rw(m_rw), .m_data(m_data), .m_q(m_q),
        .sw_in(sw_in), .led_out(led_out),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .clr_start(clr_start), .busy(busy), .ld_count(ld_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int tick_n   = 0;
    int sw_age   = 0;

    logic [15:0] mdl [4096];
    logic [15:0] led_m;
    logic [15:0] sw_m;
    logic        cnt_valid;
    logic [15:0] cnt_val;
    int          cnt_tick;

    typedef struct {
        logic        rw;
        logic [11:0] addr;
        logic [15:0] data;
        logic        chk;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        tick_n++;
        sw_age++;
    endtask

    task automatic idle();
        m_rw = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; clr_start = 1'b0;
    endtask

    function automatic logic in_io(input logic [11:0] a);
        return a >= 12'hFF0;
    endfunction

    task automatic rd(input logic [11:0] a, input logic [15:0] exp, input string name);
        m_rw = 1'b0; m_addr = a;
        tick();
        check(name, m_q, exp);
    endtask

    // Random bulk load, with the processor trying to write in parallel.
    task automatic do_load();
        logic [11:0] base;
        logic [11:0] a;
        logic [15:0] d;
        int          len;
        case ($urandom_range(0, 2))
            0:       base = 12'(($urandom_range(0, 4095)));
            1:       base = 12'hFEC + 12'($urandom_range(0, 8));
            default: base = 12'hFFA + 12'($urandom_range(0, 5));
        endcase
        len = $urandom_range(1, 6);
        ld_base = base; ld_start = 1'b1; m_rw = 1'b0;
        tick();
        ld_start = 1'b0;
        check("rnd_load_busy", busy, 1);
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 2) == 0) begin
                ld_valid = 1'b0;
                m_rw = 1'($urandom_range(0, 1)); m_addr = 12'($urandom_range(0, 63)); m_data = 16'($urandom);
                tick();
                check("rnd_load_mq", m_q, 0);
            end
            d = 16'($urandom);
            ld_valid = 1'b1; ld_data = d; ld_last = (i == len - 1);
            m_rw = 1'($urandom_range(0, 1)); m_addr = 12'($urandom_range(0, 63)); m_data = 16'($urandom);
            tick();
            a = base + 12'(i);
            if (!in_io(a)) mdl[a] = d;
        end
        idle();
        check("rnd_load_done", busy, 0);
        check("rnd_load_count", ld_count, 13'(len));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v1;
        int          n;
        int          nz;
        logic [11:0] a;
        logic [15:0] d;
        logic [15:0] exp;
        logic        rw;

        reset = 1'b1; idle();
        m_addr = '0; m_data = '0; sw_in = '0; ld_base = '0; ld_data = '0;
        #12;
        check("rst_mq", m_q, 0);
        check("rst_led", led_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ld_ready, 0);
        check("rst_count", ld_count, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        vt.push_back('{1'b0, 12'hFF2, 16'h0000, 1'b1, 16'h0000, "rd_cycle0"});
        vt.push_back('{1'b1, 12'h005, 16'h1234, 1'b0, 16'h0000, "wr005"});
        vt.push_back('{1'b0, 12'h005, 16'h0000, 1'b1, 16'h1234, "rd005"});
        vt.push_back('{1'b0, 12'hFF1, 16'h0000, 1'b1, 16'h0000, "rd_led0"});
        vt.push_back('{1'b1, 12'hFF1, 16'hA5A5, 1'b1, 16'h0000, "wr_led_readfirst"});
        vt.push_back('{1'b0, 12'hFF1, 16'h0000, 1'b1, 16'hA5A5, "rd_led"});
        vt.push_back('{1'b0, 12'hFF7, 16'h0000, 1'b1, 16'h0000, "rd_io7"});
        vt.push_back('{1'b1, 12'h005, 16'hBEEF, 1'b1, 16'h1234, "rw_readfirst"});
        vt.push_back('{1'b0, 12'h005, 16'h0000, 1'b1, 16'hBEEF, "rd005_new"});
        vt.push_back('{1'b1, 12'hFF3, 16'hFFFF, 1'b1, 16'h0000, "wr_io3"});
        vt.push_back('{1'b0, 12'hFF3, 16'h0000, 1'b1, 16'h0000, "rd_io3"});
        vt.push_back('{1'b1, 12'hFFF, 16'h5555, 1'b1, 16'h0000, "wr_io15"});
        vt.push_back('{1'b0, 12'hFFF, 16'h0000, 1'b1, 16'h0000, "rd_io15"});
        vt.push_back('{1'b1, 12'hFEF, 16'hCAFE, 1'b0, 16'h0000, "wr_fef"});
        vt.push_back('{1'b0, 12'hFEF, 16'h0000, 1'b1, 16'hCAFE, "rd_fef"});
        vt.push_back('{1'b1, 12'h010, 16'h1357, 1'b0, 16'h0000, "wr010"});
        for (int i = 0; i < vt.size(); i++) begin
            m_rw = vt[i].rw; m_addr = vt[i].addr; m_data = vt[i].data;
            tick();
            if (vt[i].chk) check(vt[i].name, m_q, vt[i].exp);
        end
        m_rw = 1'b0;
        check("led_after_table", led_out, 16'hA5A5);

        // switch input through synchronizer
        sw_in = 16'h00FF;
        tick(); tick();
        rd(12'hFF0, 16'h00FF, "rd_sw");

        // free-running counter
        m_addr = 12'hFF2;
        tick();
        v1 = m_q;
        tick(); tick(); tick();
        check("cycle_delta", m_q, v1 + 16'd3);

        // bulk load across the I/O window and wrap
        ld_base = 12'hFFE; ld_start = 1'b1; m_addr = 12'h005;
        tick();
        ld_start = 1'b0;
        check("load_busy_rise", busy, 1);
        check("load_ready_rise", ld_ready, 1);
        check("load_count_zero", ld_count, 0);
        for (int w = 1; w <= 4; w++) begin
            if (w % 2 == 0) begin
                ld_valid = 1'b0; m_rw = 1'b1;
                m_addr = (w == 2) ? 12'h010 : 12'hFF1; m_data = 16'h7777;
                tick();
                check("load_mq_zero", m_q, 0);
                m_rw = 1'b0; m_addr = 12'h005;
            end
            ld_valid = 1'b1; ld_data = 16'(w); ld_last = (w == 4);
            tick();
            if (w < 4) check("load_busy_hold", busy, 1);
        end
        idle();
        check("load_busy_fall", busy, 0);
        check("load_ready_fall", ld_ready, 0);
        check("load_count", ld_count, 4);
        rd(12'h000, 16'h0003, "load_ram0");
        rd(12'h001, 16'h0004, "load_ram1");
        rd(12'h010, 16'h1357, "load_wr_ignored");
        rd(12'hFF1, 16'hA5A5, "load_led_ignored");

        // simultaneous clear and load start: clear wins
        ld_base = 12'h200; clr_start = 1'b1; ld_start = 1'b1; m_addr = 12'h005;
        tick();
        clr_start = 1'b0; ld_start = 1'b0;
        check("clr_ready_low", ld_ready, 0);
        n = 0;
        for (int k = 0; k < 5000 && busy; k++) begin
            n++;
            tick();
            if (k == 10) check("clr_mq_zero", m_q, 0);
        end
        check("clr_busy_cycles", n, 4096);
        check("clr_count_kept", ld_count, 4);
        nz = 0;
        for (int i = 0; i < 12'hFF0; i++) begin
            m_addr = 12'(i);
            tick();
            if (m_q !== 16'h0000) nz++;
        end
        check("clr_sweep_nonzero", nz, 0);

        // reset in the middle of a load
        rd(12'hFF1, 16'hA5A5, "led_before_reset");
        ld_base = 12'h100; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 16'hAAAA; tick();
        ld_data = 16'hBBBB; tick();
        ld_data = 16'hCCCC;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", ld_ready, 0);
        check("mid_rst_led", led_out, 0);
        check("mid_rst_count", ld_count, 0);
        idle();
        tick(); tick();
        reset = 1'b0;
        rd(12'h100, 16'hAAAA, "mid_rst_word0");
        rd(12'h101, 16'hBBBB, "mid_rst_word1");
        rd(12'h102, 16'h0000, "mid_rst_word2");

        // randomized traffic against a reference model
        for (int i = 0; i < 4096; i++) mdl[i] = 16'h0000;
        mdl[12'h100] = 16'hAAAA;
        mdl[12'h101] = 16'hBBBB;
        led_m = 16'h0000; sw_m = sw_in; sw_age = 10; cnt_valid = 1'b0;
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_load();
            end else begin
                if ($urandom_range(0, 7) == 0) begin
                    sw_m = 16'($urandom); sw_in = sw_m; sw_age = 0;
                end
                rw = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       a = 12'hFF0 | 12'($urandom_range(0, 15));
                    1:       a = 12'($urandom_range(0, 4095));
                    default: a = 12'($urandom_range(0, 63));
                endcase
                d = 16'($urandom);
                m_rw = rw; m_addr = a; m_data = d;
                tick();
                if (in_io(a)) begin
                    case (a - 12'hFF0)
                        12'd0: if (sw_age >= 3) check("rnd_sw", m_q, sw_m);
                        12'd1: check("rnd_led", m_q, led_m);
                        12'd2: begin
                            exp = cnt_val + 16'(tick_n - cnt_tick);
                            if (cnt_valid) check("rnd_cycle", m_q, exp);
                            cnt_valid = 1'b1; cnt_val = m_q; cnt_tick = tick_n;
                        end
                        default: check("rnd_io_zero", m_q, 0);
                    endcase
                    if (rw && a == 12'hFF1) led_m = d;
                end else begin
                    check("rnd_ram", m_q, mdl[a]);
                    if (rw) mdl[a] = d;
                end
                m_rw = 1'b0;
            end
        end
        check("rnd_led_final", led_out, led_m);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the 5-phase processor's single memory port. It serves the processor's address, read/write and write-data outputs, and returns read data on `m_q`. It contains the 2^ADDR_W×16 program/data RAM, a small memory-mapped I/O window, and two maintenance engines that run while the processor is held idle: a host bulk-load engine and a memory-clear engine.

## Interface
Parameters:
- `ADDR_W`, default 12: address width; the RAM holds 2^ADDR_W 16-bit words.
- `IO_BASE`, default 12'hFF0: base address of the 16-word I/O window. The window shadows the RAM at these addresses.

Ports:
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `m_addr`, input, ADDR_W: processor word address.
- `m_rw`, input, 1: 1 = write, 0 = read.
- `m_data`, input, 16: processor write data.
- `m_q`, output, 16: registered read data.
- `sw_in`, input, 16: asynchronous switch inputs.
- `led_out`, output, 16: LED output register.
- `ld_start`, input, 1: one-cycle pulse that starts a bulk load.
- `ld_base`, input, ADDR_W: first load address, captured on `ld_start`.
- `ld_valid`, input, 1: host load word valid.
- `ld_data`, input, 16: host load word.
- `ld_last`, input, 1: marks the final load word; qualified by `ld_valid`.
- `ld_ready`, output, 1: responder accepts a load word.
- `clr_start`, input, 1: one-cycle pulse that starts a memory clear.
- `busy`, output, 1: 1 while in LOAD or CLEAR. The top level gates processor `exec` with it.
- `ld_count`, output, ADDR_W+1: number of words accepted in the last or current load.

## Operation
- FSM states:
  - RUN: serves the processor.
  - LOAD: accepts host words.
  - CLEAR: zeroes the RAM.
- RUN transitions:
  - `clr_start` → CLEAR.
  - else `ld_start` → LOAD. Capture `ld_base` into the load pointer and zero `ld_count`.
  - If both pulse in the same cycle, CLEAR wins and `ld_start` is dropped.
- Processor reads in RUN: `m_q` gets RAM[m_addr] or the I/O value, registered.
- Processor writes in RUN (`m_rw`=1):
  - Outside the I/O window: write RAM[m_addr] ← `m_data`.
  - Inside the window: only offset 1 is writable (`led_out` ← `m_data`). Other I/O writes are discarded and never reach the RAM.
- Same-address read/write: read-first. `m_q` returns the pre-write value.
- I/O read map (offset from `IO_BASE`):
  - 0: `sw_in`, through a 2-flop synchronizer.
  - 1: `led_out`.
  - 2: low 16 bits of a free-running cycle counter, which increments every clock and wraps.
  - 3: {15'b0, `busy`}.
  - 4–15: 16'h0000.
- LOAD:
  - `ld_ready`=1 throughout.
  - Each cycle with `ld_valid`&&`ld_ready`:
    - Write `ld_data` to RAM[ptr], unless ptr is in the I/O window. In that case the word is dropped but still counted.
    - ptr ← ptr+1, wrapping modulo 2^ADDR_W.
    - `ld_count`++.
  - An accepted word with `ld_last`=1 ends the load: the next state is RUN.
  - `ld_start` and `clr_start` are ignored in LOAD.
- CLEAR:
  - Writes 0 to addresses 0 … 2^ADDR_W−1, one per cycle, then returns to RUN.
  - The I/O window is skipped; its cycles still elapse.
  - `ld_start` and `clr_start` are ignored.
- While `busy`=1: processor writes are dropped (RAM and `led_out` unchanged) and `m_q` is registered as 16'h0000.
- `ld_count` holds its value after a load until the next `ld_start`.

## Timing
- Reset values: state RUN; `m_q`=0, `led_out`=0, `ld_ready`=0, `busy`=0, `ld_count`=0, cycle counter 0, synchronizer flops 0, load pointer 0.
- RAM contents are not reset.
- Reset asserted mid-LOAD or mid-CLEAR aborts immediately. RAM keeps the words already written.
- Read latency: `m_addr` presented before edge N gives `m_q` valid after edge N, stable until edge N+1.
- Writes commit on the edge where `m_rw`=1.
- `sw_in` change to I/O read visibility: ≤3 clocks.
- `busy` and `ld_ready` rise the clock edge after `ld_start` and fall the edge after the `ld_last` word is accepted.
- CLEAR duration: exactly 2^ADDR_W cycles in CLEAR. `busy` is high for that span, starting the edge after `clr_start`.
- Load throughput: 1 word/clock.

## Test plan
- After reset, write 16'h1234 to address 0x005, then read 0x005 → `m_q`=16'h1234 one clock after the read address is presented. Read of 0xFF1 → 16'h0000.
- Write 16'hA5A5 to 0xFF1 → `led_out`=16'hA5A5, RAM[0xFF1] unchanged. Set `sw_in`=16'h00FF, wait 3 clocks, read 0xFF0 → 16'h00FF. Read 0xFF7 → 16'h0000.
- Bulk load with `ld_base`=0xFFE, 4 words 1, 2, 3, 4 (last=1 on 4), `ld_valid` toggled with gaps:
  - RAM[0xFFE] and RAM[0xFFF] untouched, RAM[0]=3, RAM[1]=4, `ld_count`=4.
  - `busy` falls one edge after word 4.
  - A processor write during the load is ignored.
- `clr_start` and `ld_start` in the same cycle → CLEAR entered, `busy` high for 4096 cycles; afterwards every non-I/O address reads 0 and `ld_count` is unchanged.
- Assert reset mid-LOAD after 2 of 5 words → state RUN, `busy`=0, `ld_ready`=0, `led_out`=0, and the 2 loaded words are still present.
